// File: rtl/rida_isa_pkg.sv
// Shared ISA definitions for the fetch path and control-unit decoders.
// Field positions, instruction classes and fetch FSM states.
package rida_isa_pkg;

  localparam int COND_HI = 31;
  localparam int COND_LO = 30;
  localparam int TIPO_HI = 29;
  localparam int TIPO_LO = 28;
  localparam int OPC_HI  = 27;
  localparam int OPC_LO  = 25;
  localparam int FMS_HI  = 24;
  localparam int FMS_LO  = 23;
  localparam int RD_HI   = 22;
  localparam int RD_LO   = 19;
  localparam int RN_HI   = 18;
  localparam int RN_LO   = 15;
  localparam int RM_HI   = 14;
  localparam int RM_LO   = 11;
  localparam int IMM_HI  = 14;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    TIPO_REG,
    TIPO_IMM,
    TIPO_MEM,
    TIPO_CTRL
  } tipo_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_splitter.sv
// Pure wiring split of a 32-bit instruction into its fields.
// imm overlaps rm on purpose; extension happens downstream.
module instr_field_splitter
  import rida_isa_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  cond,
  output logic [1:0]  tipo,
  output logic [2:0]  opcode,
  output logic [1:0]  flag_mov_shift,
  output logic [3:0]  rd,
  output logic [3:0]  rn,
  output logic [3:0]  rm,
  output logic [14:0] imm
);

  assign cond           = instr[COND_HI:COND_LO];
  assign tipo           = instr[TIPO_HI:TIPO_LO];
  assign opcode         = instr[OPC_HI:OPC_LO];
  assign flag_mov_shift = instr[FMS_HI:FMS_LO];
  assign rd             = instr[RD_HI:RD_LO];
  assign rn             = instr[RN_HI:RN_LO];
  assign rm             = instr[RM_HI:RM_LO];
  assign imm            = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem request, registered fields,
// valid/ready to decode, branch redirect with in-flight squash.
module instr_fetch_unit
  import rida_isa_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [1:0]        cond,
  output logic [1:0]        tipo,
  output logic [2:0]        opcode,
  output logic [1:0]        flag_mov_shift,
  output logic [3:0]        rd,
  output logic [3:0]        rn,
  output logic [3:0]        rm,
  output logic [14:0]       imm
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              squash;
  logic              cap;
  logic              unused_tgt;

  logic [1:0]  sp_cond, sp_tipo, sp_fms;
  logic [2:0]  sp_opc;
  logic [3:0]  sp_rd, sp_rn, sp_rm;
  logic [14:0] sp_imm;

  assign unused_tgt = ^branch_target[1:0];

  instr_field_splitter u_split (
    .instr          (imem_rdata),
    .cond           (sp_cond),
    .tipo           (sp_tipo),
    .opcode         (sp_opc),
    .flag_mov_shift (sp_fms),
    .rd             (sp_rd),
    .rn             (sp_rn),
    .rm             (sp_rm),
    .imm            (sp_imm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!branch_taken && fetch_en) state_nxt = WAIT;
      end
      WAIT: begin
        if (branch_taken)
          state_nxt = imem_rvalid ? IDLE : WAIT;
        else if (imem_rvalid && squash)
          state_nxt = fetch_en ? WAIT : IDLE;
        else if (imem_rvalid)
          state_nxt = HOLD;
      end
      HOLD: begin
        if (branch_taken)  state_nxt = IDLE;
        else if (id_ready) state_nxt = fetch_en ? WAIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      IDLE:    imem_req = fetch_en;
      WAIT:    imem_req = imem_rvalid && squash && fetch_en;
      HOLD:    imem_req = id_ready && fetch_en;
      default: imem_req = 1'b0;
    endcase
    if (branch_taken || rst) imem_req = 1'b0;
  end

  assign imem_addr = imem_req ? pc : '0;
  assign if_valid  = (state == HOLD);
  assign cap       = (state == WAIT) && imem_rvalid
                  && !squash && !branch_taken;

  // A redirect with no response yet leaves a stale word in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      squash <= 1'b0;
    end else if (branch_taken) begin
      pc     <= {branch_target[ADDR_W-1:2], 2'b00};
      squash <= (state == WAIT) && !imem_rvalid;
    end else begin
      if (state == WAIT && imem_rvalid) squash <= 1'b0;
      if (cap) pc <= pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pc          <= '0;
      cond           <= '0;
      tipo           <= '0;
      opcode         <= '0;
      flag_mov_shift <= '0;
      rd             <= '0;
      rn             <= '0;
      rm             <= '0;
      imm            <= '0;
    end else if (cap) begin
      if_pc          <= pc;
      cond           <= sp_cond;
      tipo           <= sp_tipo;
      opcode         <= sp_opc;
      flag_mov_shift <= sp_fms;
      rd             <= sp_rd;
      rn             <= sp_rn;
      rm             <= sp_rm;
      imm            <= sp_imm;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic fetch_en, id_ready, branch_taken, imem_rvalid;
  logic [31:0] branch_target, imem_rdata;

  logic        req0, req1, v0, v1;
  logic [31:0] addr0, addr1, pc0, pc1;
  logic [1:0]  cond0, tipo0, fms0, cond1, tipo1, fms1;
  logic [2:0]  opc0, opc1;
  logic [3:0]  rd0, rn0, rm0, rd1, rn1, rm1;
  logic [14:0] imm0, imm1;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req(req0), .imem_addr(addr0),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_ready(id_ready), .if_valid(v0), .if_pc(pc0),
    .cond(cond0), .tipo(tipo0), .opcode(opc0),
    .flag_mov_shift(fms0), .rd(rd0), .rn(rn0), .rm(rm0),
    .imm(imm0)
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req(req1), .imem_addr(addr1),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_ready(id_ready), .if_valid(v1), .if_pc(pc1),
    .cond(cond1), .tipo(tipo1), .opcode(opc1),
    .flag_mov_shift(fms1), .rd(rd1), .rn(rn1), .rm(rm1),
    .imm(imm1)
  );

  int checks = 0;
  int errors = 0;

  // memory and stream model
  int          lat = 1;
  int          cnt = 0;
  bit          pend = 0, stale = 0, m_valid = 0;
  logic [31:0] paddr = '0, m_req_pc = '0, m_pc = '0, m_ipc = '0;

  // per-cycle captures and expectations
  logic        c_req, c_valid, c_rv, c_req1;
  logic [31:0] c_addr, c_pc, c_addr1, c_pc1;
  logic [20:0] c_hi;
  logic [14:0] c_imm;
  logic        e_req, e_valid;
  logic [31:0] e_addr, e_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A9C_8ABC;
  endfunction

  task automatic step();
    bit good;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend) begin
      if (cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(paddr);
      end else cnt--;
    end
    @(negedge clk);
    good    = imem_rvalid && !stale && !branch_taken;
    e_valid = m_valid;
    e_pc    = m_ipc;
    e_addr  = m_pc;
    e_req   = fetch_en && !branch_taken
           && !(pend && !imem_rvalid)
           && !((m_valid && !id_ready) || good);
    c_req   = req0;  c_addr  = addr0;
    c_valid = v0;    c_pc    = pc0;
    c_rv    = imem_rvalid;
    c_req1  = req1;  c_addr1 = addr1;  c_pc1 = pc1;
    c_hi    = {cond0, tipo0, opc0, fms0, rd0, rn0, rm0};
    c_imm   = imm0;
    if (imem_rvalid) begin
      pend  = 0;
      stale = 0;
    end
    if (branch_taken) begin
      m_pc    = {branch_target[31:2], 2'b00};
      m_valid = 0;
      if (pend) stale = 1;
    end else begin
      if (m_valid && id_ready) m_valid = 0;
      if (good) begin
        m_valid = 1;
        m_ipc   = m_req_pc;
        m_pc    = m_req_pc + 32'd4;
      end
    end
    if (req0) begin
      pend     = 1;
      cnt      = lat;
      paddr    = addr0;
      m_req_pc = m_pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_en = 0; id_ready = 0; branch_taken = 0;
    branch_target = '0; imem_rvalid = 0; imem_rdata = '0;
    pend = 0; stale = 0; m_valid = 0; cnt = 0;
    m_pc = '0; m_ipc = '0; m_req_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_en = 1; id_ready = 1; branch_taken = 0;
    branch_target = '0; imem_rvalid = 0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0, addr0} !== 33'd0) begin
      errors++;
      $display("FAIL reset_req0: got %0b/%h want 0/0", req0, addr0);
    end
    checks++;
    if ({v0, pc0} !== 33'd0) begin
      errors++;
      $display("FAIL reset_out0: got %0b/%h want 0/0", v0, pc0);
    end
    checks++;
    if ({cond0, tipo0, opc0, fms0, rd0, rn0, rm0, imm0} !== 36'd0) begin
      errors++;
      $display("FAIL reset_fields0: got nonzero want 0");
    end
    checks++;
    if ({req1, addr1, v1, pc1} !== 66'd0) begin
      errors++;
      $display("FAIL reset_dut1: got %0b/%h/%0b/%h want all 0",
               req1, addr1, v1, pc1);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    lat = 1; fetch_en = 1; id_ready = 1;
    step();
    checks++;
    if (c_req !== 1'b1 || c_addr !== 32'h0) begin
      errors++;
      $display("FAIL basic_req0: got %0b/%h want 1/0", c_req, c_addr);
    end
    step();
    checks++;
    if (c_valid !== 1'b0 || c_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait: got v=%0b req=%0b want 0/0",
               c_valid, c_req);
    end
    step();
    checks++;
    if (c_valid !== 1'b1 || c_pc !== 32'h0) begin
      errors++;
      $display("FAIL basic_out: got v=%0b pc=%h want 1/0", c_valid, c_pc);
    end
    checks++;
    if (c_hi !== {2'd1, 2'd1, 3'd5, 2'd1, 4'd3, 4'd9, 4'd1}) begin
      errors++;
      $display("FAIL basic_fields: got %h want %h", c_hi,
               {2'd1, 2'd1, 3'd5, 2'd1, 4'd3, 4'd9, 4'd1});
    end
    checks++;
    if (c_imm !== 15'h0ABC) begin
      errors++;
      $display("FAIL basic_imm: got %h want 0abc", c_imm);
    end
    checks++;
    if (c_req !== 1'b1 || c_addr !== 32'h4) begin
      errors++;
      $display("FAIL basic_req1: got %0b/%h want 1/4", c_req, c_addr);
    end
  endtask

  task automatic test_stall();
    logic [20:0] hv;
    logic [14:0] iv;
    logic [31:0] pv;
    bit done = 0;
    do_reset();
    lat = 2; fetch_en = 1; id_ready = 0;
    step();
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      done = c_valid;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL stall_timeout: got no valid want valid");
    end
    hv = c_hi; iv = c_imm; pv = c_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (c_valid !== 1'b1 || c_req !== 1'b0
          || {c_hi, c_imm, c_pc} !== {hv, iv, pv}) begin
        errors++;
        $display("FAIL stall_hold %0d: got v=%0b req=%0b pc=%h want 1/0/%h",
                 i, c_valid, c_req, c_pc, pv);
      end
    end
    id_ready = 1;
    step();
    checks++;
    if (c_req !== 1'b1 || c_addr !== pv + 32'd4) begin
      errors++;
      $display("FAIL stall_req: got %0b/%h want 1/%h",
               c_req, c_addr, pv + 32'd4);
    end
    step();
    checks++;
    if (c_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_once: got v=%0b want 0", c_valid);
    end
  endtask

  task automatic test_branch_squash();
    bit seen = 0;
    bit done = 0;
    do_reset();
    lat = 3; fetch_en = 1; id_ready = 1;
    step();
    branch_taken = 1; branch_target = 32'h0000_0103;
    step();
    checks++;
    if (c_req !== 1'b0) begin
      errors++;
      $display("FAIL sq_br_req: got %0b want 0", c_req);
    end
    branch_taken = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      step();
      if (c_req && !seen) begin
        seen = 1;
        checks++;
        if (c_rv !== 1'b1 || c_addr !== 32'h100) begin
          errors++;
          $display("FAIL sq_refetch: got rv=%0b addr=%h want 1/100",
                   c_rv, c_addr);
        end
      end
      checks++;
      if (c_valid && !seen) begin
        errors++;
        $display("FAIL sq_stale: got valid pc=%h want none", c_pc);
      end
      if (c_valid) begin
        done = 1;
        checks++;
        if (c_pc !== 32'h100) begin
          errors++;
          $display("FAIL sq_pc: got %h want 100", c_pc);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL sq_timeout: got no valid want valid");
    end
  endtask

  task automatic test_branch_coincident();
    bit done = 0;
    do_reset();
    lat = 2; fetch_en = 1; id_ready = 1;
    step();
    step();
    branch_taken = 1; branch_target = 32'h40;
    step();
    checks++;
    if (c_rv !== 1'b1 || c_req !== 1'b0) begin
      errors++;
      $display("FAIL co_cycle: got rv=%0b req=%0b want 1/0", c_rv, c_req);
    end
    branch_taken = 0;
    step();
    checks++;
    if (c_valid !== 1'b0 || c_req !== 1'b1 || c_addr !== 32'h40) begin
      errors++;
      $display("FAIL co_req: got v=%0b req=%0b addr=%h want 0/1/40",
               c_valid, c_req, c_addr);
    end
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      done = c_valid;
    end
    checks++;
    if (!done || c_pc !== 32'h40) begin
      errors++;
      $display("FAIL co_out: got done=%0b pc=%h want 1/40", done, c_pc);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    lat = 1; fetch_en = 1; id_ready = 1;
    step();
    checks++;
    if (c_req1 !== 1'b1 || c_addr1 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req0: got %0b/%h want 1/fffffffc",
               c_req1, c_addr1);
    end
    step();
    step();
    checks++;
    if (c_pc1 !== 32'hFFFF_FFFC || c_req1 !== 1'b1 || c_addr1 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: got pc=%h req=%0b addr=%h want fffffffc/1/0",
               c_pc1, c_req1, c_addr1);
    end
    checks++;
    if (v0 !== 1'b0 || v1 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_inwait: got v=%0b/%0b want 0/0", v0, v1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req0, addr0, v0, pc0, req1, addr1, v1, pc1} !== 132'd0) begin
      errors++;
      $display("FAIL async_ctl: got pc0=%h pc1=%h v=%0b%0b want 0",
               pc0, pc1, v0, v1);
    end
    checks++;
    if ({cond0, tipo0, opc0, fms0, rd0, rn0, rm0, imm0,
         cond1, tipo1, opc1, fms1, rd1, rn1, rm1, imm1} !== 72'd0) begin
      errors++;
      $display("FAIL async_fields: got nonzero want 0");
    end
    @(posedge clk);
    do_reset();
  endtask

  task automatic test_fetch_en_low();
    bit done = 0;
    do_reset();
    lat = 3; fetch_en = 1; id_ready = 0;
    step();
    fetch_en = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      checks++;
      if (c_req !== 1'b0) begin
        errors++;
        $display("FAIL fe_noreq %0d: got %0b want 0", i, c_req);
      end
      done = c_valid;
    end
    checks++;
    if (!done || c_pc !== 32'h0) begin
      errors++;
      $display("FAIL fe_out: got done=%0b pc=%h want 1/0", done, c_pc);
    end
    id_ready = 1;
    step();
    checks++;
    if (c_valid !== 1'b1 || c_req !== 1'b0) begin
      errors++;
      $display("FAIL fe_hs: got v=%0b req=%0b want 1/0", c_valid, c_req);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (c_valid !== 1'b0 || c_req !== 1'b0) begin
        errors++;
        $display("FAIL fe_idle %0d: got v=%0b req=%0b want 0/0",
                 i, c_valid, c_req);
      end
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 imem_rvalid = 1'b0;
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("FAIL fe_spurious: got v=%0b want 0", v0);
    end
    fetch_en = 1;
    step();
    checks++;
    if (c_req !== 1'b1 || c_addr !== 32'h4) begin
      errors++;
      $display("FAIL fe_resume: got %0b/%h want 1/4", c_req, c_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 3000 && errors < 20; i++) begin
      fetch_en      = ($urandom_range(0, 9) < 8);
      id_ready      = ($urandom_range(0, 9) < 7);
      branch_taken  = ($urandom_range(0, 99) < 8);
      branch_target = $urandom();
      lat           = $urandom_range(1, 4);
      step();
      checks++;
      if (c_req !== e_req) begin
        errors++;
        $display("FAIL rnd_req cyc %0d: got %0b want %0b", i, c_req, e_req);
      end
      if (e_req) begin
        checks++;
        if (c_addr !== e_addr) begin
          errors++;
          $display("FAIL rnd_addr cyc %0d: got %h want %h",
                   i, c_addr, e_addr);
        end
      end
      checks++;
      if (c_valid !== e_valid) begin
        errors++;
        $display("FAIL rnd_valid cyc %0d: got %0b want %0b",
                 i, c_valid, e_valid);
      end
      if (e_valid) begin
        w = word_of(e_pc);
        checks++;
        if ({c_pc, c_hi, c_imm} !== {e_pc, w[31:11], w[14:0]}) begin
          errors++;
          $display("FAIL rnd_out cyc %0d: got pc=%h f=%h/%h want %h/%h/%h",
                   i, c_pc, c_hi, c_imm, e_pc, w[31:11], w[14:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch_squash();
    test_branch_coincident();
    test_wrap_reset();
    test_fetch_en_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
